lock_clear_ctrl: RTL and testbench
==================================

// Module: lock_clear_ctrl
// PURPOSE
//  Sequences the post-lock pipeline of the playfield: merge the locked piece, run clean_field, commit the cleaned field, request the next spawn.
//  Owns scoring, total-line count, level and gravity period.
//  Sits between the game FSM (lock/spawn handshake) and the field datapath (merger, clean_field, field register).
// PARAMETERS
//  SCORE_W          24   score width; score saturates at 2^SCORE_W-1
//  LINES_W          16   lines_total width; saturates at max
//  LINES_PER_LEVEL  10   lines per level step; must be >= 4
//  MAX_LEVEL        15   level saturates here
//  BASE_DROP        48   drop_ticks at level 0
//  DROP_STEP        3    drop_ticks decrement per level
//  MIN_DROP         3    drop_ticks floor
//  TIMEOUT          1023 max CLEAN-state cycles before abort
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        async active-low reset
//  new_game       in   1        clear stats; honoured in IDLE only
//  lock_req       in   1        piece locked; sampled in IDLE only
//  busy           out  1        high in every state except IDLE
//  merge_en       out  1        1-cycle pulse: merger writes piece into field
//  clean_en       out  1        level enable to clean_field
//  clean_done     in   1        clean_field done
//  clean_lines    in   3        clean_field lines_cleared
//  field_we       out  1        1-cycle pulse: field register loads clean_field f_out
//  spawn_req      out  1        next-piece request, held until spawn_ack
//  spawn_ack      in   1        spawner accepted request
//  spawn_blocked  in   1        valid with spawn_ack: spawn position occupied
//  game_over      out  1        sticky; set on blocked spawn
//  score          out  SCORE_W  accumulated score
//  lines_total    out  LINES_W  total lines cleared
//  level          out  4        current level
//  drop_ticks     out  8        gravity period for drop timer
//  timeout_err    out  1        sticky; clean_field failed to finish
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; all outputs 0 except drop_ticks=BASE_DROP; internal lines_in_level=0.
//  States: IDLE -> MERGE -> CLEAN -> COMMIT -> SPAWN -> IDLE.
//  IDLE: new_game=1 clears score, lines_total, level, lines_in_level, game_over, timeout_err (new_game wins over lock_req same cycle; lock_req then dropped).
//   lock_req=1 and game_over=0 -> MERGE. lock_req with game_over=1 ignored.
//  MERGE: merge_en=1 for exactly this cycle -> CLEAN.
//  CLEAN: clean_en=1; count cycles. clean_done=1 -> latch clean_lines (values >4 clamp to 4) -> COMMIT.
//   Count reaching TIMEOUT without done -> timeout_err=1, no field_we, no score -> SPAWN.
//  COMMIT: clean_en=0 (guarantees clean_field returns to IDLE before next run); field_we=1 this cycle.
//   Score add = {0,40,100,300,1200}[n]*(level+1), saturating; level is pre-update value.
//   lines_total += n saturating; lines_in_level += n; if >= LINES_PER_LEVEL: subtract it, level++ (saturate MAX_LEVEL).
//   -> SPAWN. All stat registers update on the COMMIT edge.
//  SPAWN: spawn_req=1 until spawn_ack. On ack: spawn_blocked=1 -> game_over=1. -> IDLE.
//  drop_ticks registered: max(MIN_DROP, BASE_DROP - level*DROP_STEP); updates cycle after level changes.
//  lock_req/new_game outside IDLE: ignored, no queueing.
//  clean_en is never high in two consecutive runs without >= 2 low cycles between (COMMIT+SPAWN).
//  Latency lock_req -> field_we: 3 + clean_field run time cycles.
//  Reset mid-operation: immediate return to IDLE, all pulses/requests drop asynchronously.
// TESTING
//  1. Reset, lock_req, clean model returns done after 5 cycles with lines=0 -> merge_en@t+1, field_we once, score=0, spawn_req until ack.
//  2. level=0, clear 4 lines -> score=1200, lines_total=4; then at level 1 clear 2 -> score=1400.
//  3. LINES_PER_LEVEL=10: clears 4,4,3 -> level=1, lines_in_level=1, drop_ticks=45 after third commit.
//  4. Done never asserted -> timeout_err=1 after TIMEOUT cycles, no field_we, spawn_req still issued.
//  5. spawn_ack with spawn_blocked=1 -> game_over=1; later lock_req ignored; new_game in IDLE clears all stats.
//  6. rst_n low during CLEAN -> clean_en, busy low immediately; score/lines preserved? no: all 0; lock_req next accepted.
//  Also: score at 2^24-100 plus 1200 add -> saturates at 2^24-1.

Source files
------------

// File: rtl/lock_clear_ctrl.sv
// lock_clear_ctrl: sequences merge -> clean -> commit -> spawn after a lock,
// and keeps score, line total, level and the gravity period.
module lock_clear_ctrl #(
  parameter int SCORE_W         = 24,
  parameter int LINES_W         = 16,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 15,
  parameter int BASE_DROP       = 48,
  parameter int DROP_STEP       = 3,
  parameter int MIN_DROP        = 3,
  parameter int TIMEOUT         = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_game,
  input  logic               lock_req,
  output logic               busy,
  output logic               merge_en,
  output logic               clean_en,
  input  logic               clean_done,
  input  logic [2:0]         clean_lines,
  output logic               field_we,
  output logic               spawn_req,
  input  logic               spawn_ack,
  input  logic               spawn_blocked,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [LINES_W-1:0] lines_total,
  output logic [3:0]         level,
  output logic [7:0]         drop_ticks,
  output logic               timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LINES_PER_LEVEL + 4);

  typedef enum logic [2:0] {
    S_IDLE, S_MERGE, S_CLEAN, S_COMMIT, S_SPAWN
  } state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_n;
  logic [SCORE_W-1:0] r_score;
  logic [LINES_W-1:0] r_lines;
  logic [3:0]         r_level;
  logic [LW-1:0]      r_lil;
  logic [7:0]         r_drop;
  logic               r_go;
  logic               r_tmo;

  logic               w_tmo_hit;
  logic [2:0]         w_nclamp;
  logic [10:0]        w_base;
  logic [4:0]         w_mult;
  logic [15:0]        w_add;
  logic [SCORE_W:0]   w_ssum;
  logic [LINES_W:0]   w_lsum;
  logic [LW-1:0]      w_lil;
  logic               w_lvl_up;
  logic [7:0]         w_drop;
  int                 w_dtmp;

  assign w_tmo_hit = (r_cnt == CW'(TIMEOUT - 1));
  assign w_nclamp  = (clean_lines > 3'd4) ? 3'd4 : clean_lines;
  assign w_mult    = {1'b0, r_level} + 5'd1;
  assign w_add     = 16'(w_base) * 16'(w_mult);
  assign w_ssum    = {1'b0, r_score} + (SCORE_W + 1)'(w_add);
  assign w_lsum    = {1'b0, r_lines} + (LINES_W + 1)'(r_n);
  assign w_lil     = r_lil + LW'(r_n);
  assign w_lvl_up  = (w_lil >= LW'(LINES_PER_LEVEL));

  always_comb begin
    w_base = 11'd0;
    unique case (r_n)
      3'd1:    w_base = 11'd40;
      3'd2:    w_base = 11'd100;
      3'd3:    w_base = 11'd300;
      3'd4:    w_base = 11'd1200;
      default: w_base = 11'd0;
    endcase
  end

  always_comb begin
    w_dtmp = BASE_DROP - int'(r_level) * DROP_STEP;
    w_drop = (w_dtmp < MIN_DROP) ? 8'(MIN_DROP) : 8'(w_dtmp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    merge_en  = 1'b0;
    clean_en  = 1'b0;
    field_we  = 1'b0;
    spawn_req = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (!new_game && lock_req && !r_go) w_next = S_MERGE;
      end
      S_MERGE: begin
        merge_en = 1'b1;
        w_next   = S_CLEAN;
      end
      S_CLEAN: begin
        clean_en = 1'b1;
        if (clean_done)     w_next = S_COMMIT;
        else if (w_tmo_hit) w_next = S_SPAWN;
      end
      S_COMMIT: begin
        field_we = 1'b1;
        w_next   = S_SPAWN;
      end
      S_SPAWN: begin
        spawn_req = 1'b1;
        if (spawn_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_n     <= '0;
      r_score <= '0;
      r_lines <= '0;
      r_level <= '0;
      r_lil   <= '0;
      r_drop  <= 8'(BASE_DROP);
      r_go    <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_drop <= w_drop;
      r_cnt  <= (r_state == S_CLEAN) ? r_cnt + CW'(1) : '0;
      if (r_state == S_IDLE && new_game) begin
        r_score <= '0;
        r_lines <= '0;
        r_level <= '0;
        r_lil   <= '0;
        r_go    <= 1'b0;
        r_tmo   <= 1'b0;
      end
      if (r_state == S_CLEAN) begin
        if (clean_done)     r_n   <= w_nclamp;
        else if (w_tmo_hit) r_tmo <= 1'b1;
      end
      if (r_state == S_COMMIT) begin
        r_score <= w_ssum[SCORE_W] ? '1 : w_ssum[SCORE_W-1:0];
        r_lines <= w_lsum[LINES_W] ? '1 : w_lsum[LINES_W-1:0];
        if (w_lvl_up) begin
          r_lil <= w_lil - LW'(LINES_PER_LEVEL);
          if (r_level != 4'(MAX_LEVEL)) r_level <= r_level + 4'd1;
        end else begin
          r_lil <= w_lil;
        end
      end
      if (r_state == S_SPAWN && spawn_ack && spawn_blocked) r_go <= 1'b1;
    end
  end

  assign score       = r_score;
  assign lines_total = r_lines;
  assign level       = r_level;
  assign drop_ticks  = r_drop;
  assign game_over   = r_go;
  assign timeout_err = r_tmo;

endmodule

// File: tb/tb_lock_clear_ctrl.sv
// tb_lock_clear_ctrl: directed scenarios for lock_clear_ctrl with an
// inline clean_field/spawner model driven from the stimulus tasks.
module tb_lock_clear_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_game = 1'b0;
  logic        lock_req = 1'b0;
  logic        clean_done = 1'b0;
  logic [2:0]  clean_lines = 3'd0;
  logic        spawn_ack = 1'b0;
  logic        spawn_blocked = 1'b0;
  logic        busy, merge_en, clean_en, field_we, spawn_req;
  logic        game_over, timeout_err;
  logic [23:0] score;
  logic [15:0] lines_total;
  logic [3:0]  level;
  logic [7:0]  drop_ticks;

  int errors = 0;
  int checks = 0;
  int we_cnt, we_idx, clean_cyc, spawn_cyc;
  bit merge_ok;

  localparam longint SMAX = 64'd16777215;

  always #5 clk = ~clk;

  lock_clear_ctrl dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .lock_req(lock_req),
    .busy(busy), .merge_en(merge_en), .clean_en(clean_en),
    .clean_done(clean_done), .clean_lines(clean_lines),
    .field_we(field_we), .spawn_req(spawn_req), .spawn_ack(spawn_ack),
    .spawn_blocked(spawn_blocked), .game_over(game_over), .score(score),
    .lines_total(lines_total), .level(level), .drop_ticks(drop_ticks),
    .timeout_err(timeout_err)
  );

  // One lock: clean_done rises on the dly-th clean_en cycle (dly=0: never).
  task automatic do_piece(input int n, input int dly, input bit blk);
    int k;
    int cc;
    we_cnt = 0; we_idx = -1; clean_cyc = 0; spawn_cyc = 0; cc = 0;
    @(negedge clk); lock_req = 1'b1; clean_lines = 3'(n);
    @(negedge clk); lock_req = 1'b0;
    merge_ok = merge_en && busy;
    k = 0;
    while (!spawn_req && k < 3000) begin
      @(negedge clk); k++;
      clean_done = 1'b0;
      if (field_we) begin we_cnt++; we_idx = k; end
      if (clean_en) begin
        cc++; clean_cyc++;
        clean_done = (dly > 0 && cc == dly);
      end
    end
    if (!spawn_req) begin
      errors++;
      $display("FAIL piece_wait: spawn_req=%b required 1", spawn_req);
    end
    checks++;
    spawn_cyc = 1;
    repeat (2) begin
      @(negedge clk);
      if (spawn_req) spawn_cyc++;
    end
    spawn_ack = 1'b1; spawn_blocked = blk;
    @(negedge clk); spawn_ack = 1'b0; spawn_blocked = 1'b0;
  endtask

  task automatic pulse_new_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, merge_en, clean_en, field_we, spawn_req, game_over,
         timeout_err} !== 7'd0 || score !== 24'd0 ||
        lines_total !== 16'd0 || level !== 4'd0) begin
      errors++;
      $display("FAIL reset_outs: busy=%b score=%0d lines=%0d level=%0d required all 0",
               busy, score, lines_total, level);
    end
    checks++;
    if (drop_ticks !== 8'd48) begin
      errors++;
      $display("FAIL reset_drop: got %0d required 48", drop_ticks);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic();
    do_piece(0, 5, 1'b0);
    checks++;
    if (merge_ok !== 1'b1) begin
      errors++;
      $display("FAIL basic_merge: merge_en@t+1=%b required 1", merge_ok);
    end
    checks++;
    if (we_cnt != 1 || we_idx != 6) begin
      errors++;
      $display("FAIL basic_we: count=%0d at=%0d required 1 at 6", we_cnt, we_idx);
    end
    checks++;
    if (score !== 24'd0) begin
      errors++;
      $display("FAIL basic_score: got %0d required 0", score);
    end
    checks++;
    if (spawn_cyc != 3) begin
      errors++;
      $display("FAIL basic_spawn_hold: got %0d required 3", spawn_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_scoring();
    do_piece(4, 3, 1'b0);
    checks++;
    if (score !== 24'd1200 || lines_total !== 16'd4 || level !== 4'd0) begin
      errors++;
      $display("FAIL tetris_l0: score=%0d lines=%0d level=%0d required 1200 4 0",
               score, lines_total, level);
    end
  endtask

  task automatic test_level();
    do_piece(4, 3, 1'b0);
    do_piece(3, 3, 1'b0);
    checks++;
    if (score !== 24'd2700 || lines_total !== 16'd11 || level !== 4'd1) begin
      errors++;
      $display("FAIL level_up: score=%0d lines=%0d level=%0d required 2700 11 1",
               score, lines_total, level);
    end
    checks++;
    if (drop_ticks !== 8'd45) begin
      errors++;
      $display("FAIL drop_l1: got %0d required 45", drop_ticks);
    end
    do_piece(2, 2, 1'b0);
    checks++;
    if (score !== 24'd2900) begin
      errors++;
      $display("FAIL double_l1: got %0d required 2900", score);
    end
    do_piece(7, 2, 1'b0);
    checks++;
    if (score !== 24'd5300 || lines_total !== 16'd17 || level !== 4'd1) begin
      errors++;
      $display("FAIL clamp_l1: score=%0d lines=%0d level=%0d required 5300 17 1",
               score, lines_total, level);
    end
    do_piece(3, 1, 1'b0);
    checks++;
    if (score !== 24'd5900 || lines_total !== 16'd20 || level !== 4'd2 ||
        drop_ticks !== 8'd42) begin
      errors++;
      $display("FAIL level2: score=%0d lines=%0d level=%0d drop=%0d required 5900 20 2 42",
               score, lines_total, level, drop_ticks);
    end
  endtask

  task automatic test_timeout();
    do_piece(0, 0, 1'b0);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_flag: got %b required 1", timeout_err);
    end
    checks++;
    if (we_cnt != 0 || clean_cyc != 1023) begin
      errors++;
      $display("FAIL tmo_cycles: we=%0d clean=%0d required 0 1023", we_cnt, clean_cyc);
    end
    checks++;
    if (spawn_cyc != 3 || score !== 24'd5900) begin
      errors++;
      $display("FAIL tmo_spawn: spawn=%0d score=%0d required 3 5900", spawn_cyc, score);
    end
  endtask

  task automatic test_game_over();
    do_piece(1, 2, 1'b1);
    checks++;
    if (game_over !== 1'b1 || score !== 24'd6020) begin
      errors++;
      $display("FAIL go_set: go=%b score=%0d required 1 6020", game_over, score);
    end
    @(negedge clk); lock_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || merge_en !== 1'b0) begin
        errors++;
        $display("FAIL go_ignore: busy=%b merge=%b required 0 0", busy, merge_en);
      end
    end
    lock_req = 1'b0;
    pulse_new_game();
    checks++;
    if (score !== 24'd0 || lines_total !== 16'd0 || level !== 4'd0 ||
        game_over !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL newgame_clear: score=%0d lines=%0d level=%0d go=%b tmo=%b required 0",
               score, lines_total, level, game_over, timeout_err);
    end
    @(negedge clk);
    checks++;
    if (drop_ticks !== 8'd48) begin
      errors++;
      $display("FAIL newgame_drop: got %0d required 48", drop_ticks);
    end
  endtask

  task automatic test_new_game_wins();
    @(negedge clk); lock_req = 1'b1; new_game = 1'b1;
    @(negedge clk); lock_req = 1'b0; new_game = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ng_wins: busy=%b required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ng_dropped: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    do_piece(4, 2, 1'b0);
    @(negedge clk); lock_req = 1'b1;
    @(negedge clk); lock_req = 1'b0;
    @(negedge clk);
    checks++;
    if (clean_en !== 1'b1 || score !== 24'd1200) begin
      errors++;
      $display("FAIL rm_pre: clean_en=%b score=%0d required 1 1200", clean_en, score);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (clean_en !== 1'b0 || busy !== 1'b0 || score !== 24'd0) begin
      errors++;
      $display("FAIL rm_async: clean_en=%b busy=%b score=%0d required 0 0 0",
               clean_en, busy, score);
    end
    @(negedge clk); rst_n = 1'b1;
    do_piece(1, 2, 1'b0);
    checks++;
    if (merge_ok !== 1'b1 || score !== 24'd40) begin
      errors++;
      $display("FAIL rm_after: merge=%b score=%0d required 1 40", merge_ok, score);
    end
  endtask

  task automatic test_saturation();
    longint ms;
    int lvl;
    int lil;
    bit bad;
    ms = 0; lvl = 0; lil = 0; bad = 1'b0;
    pulse_new_game();
    for (int i = 0; i < 1500 && ms < SMAX && !bad; i++) begin
      do_piece(4, 1, 1'b0);
      ms = ms + 1200 * (lvl + 1);
      if (ms > SMAX) ms = SMAX;
      lil = lil + 4;
      if (lil >= 10) begin
        lil = lil - 10;
        if (lvl < 15) lvl++;
      end
      checks++;
      if (score !== 24'(ms) || level !== 4'(lvl)) begin
        errors++; bad = 1'b1;
        $display("FAIL sat_track: score=%0d level=%0d required %0d %0d",
                 score, level, ms, lvl);
      end
    end
    do_piece(4, 1, 1'b0);
    checks++;
    if (score !== 24'hFFFFFF || drop_ticks !== 8'd3) begin
      errors++;
      $display("FAIL sat_hold: score=%0d drop=%0d required 16777215 3",
               score, drop_ticks);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scoring();
    test_level();
    test_timeout();
    test_game_over();
    test_new_game_wins();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
